elevator_scan_ctrl: RTL and testbench

//  Parametrised N-floor elevator controller. Replaces the fixed 3-floor, externally timed controller.
//  - Latches floor call pulses into a pending-request vector.
//  - Schedules requests with SCAN: keeps direction while requests lie ahead, then reverses.
//  - Generates floor-travel and door-dwell timing internally.
//  - Sits between the call-button encoder and the motor/door drivers.

---
 rtl/elevator_scan_ctrl.sv | 175 +++++++++++++++++
 tb/tb_elevator_scan_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: N-floor elevator controller with SCAN scheduling.
// Call pulses are latched into a pending vector. The car keeps its direction
// while requests lie ahead, then reverses. Floor travel time and door dwell
// time are counted internally.
module elevator_scan_ctrl #(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS),
    parameter int TRAVEL_CYC = 4,
    parameter int DOOR_CYC   = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic                  door_hold,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic [1:0]            motor_dir,
    output logic                  door,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  arrive
);

    localparam int TRV_W = (TRAVEL_CYC > 1) ? $clog2(TRAVEL_CYC) : 1;
    localparam int DWL_W = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;
    localparam logic [TRV_W-1:0] TRV_LAST = TRV_W'(TRAVEL_CYC - 1);
    localparam logic [DWL_W-1:0] DWL_LAST = DWL_W'(DOOR_CYC - 1);

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DN   = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        MOVING_UP,
        MOVING_DN,
        DOOR_OPEN
    } state_t;

    state_t               state;
    logic                 dir_last_up;
    logic [TRV_W-1:0]     travel_cnt;
    logic [DWL_W-1:0]     dwell_cnt;

    logic [NUM_FLOORS-1:0] req;
    logic [NUM_FLOORS-1:0] pend_base;
    logic                  above;
    logic                  below;
    logic [FLOOR_W-1:0]    floor_up;
    logic [FLOOR_W-1:0]    floor_dn;

    // True when any request lies strictly above floor f.
    function automatic logic any_above(input logic [NUM_FLOORS-1:0] v,
                                       input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (i > int'(f) && v[i]) r = 1'b1;
        return r;
    endfunction

    // True when any request lies strictly below floor f.
    function automatic logic any_below(input logic [NUM_FLOORS-1:0] v,
                                       input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (i < int'(f) && v[i]) r = 1'b1;
        return r;
    endfunction

    // Request view used for decisions this cycle, and the next pending value.
    // A call for the open-door floor is never latched; it only extends dwell.
    always_comb begin
        req       = pending | call_req;
        above     = any_above(req, current_floor);
        below     = any_below(req, current_floor);
        floor_up  = current_floor + FLOOR_W'(1);
        floor_dn  = current_floor - FLOOR_W'(1);
        pend_base = req;
        if (state == DOOR_OPEN)
            pend_base[current_floor] = 1'b0;
    end

    // Controller FSM with registered Moore outputs and request latching.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            current_floor <= '0;
            pending       <= '0;
            dir_last_up   <= 1'b1;
            motor_dir     <= DIR_STOP;
            door          <= 1'b0;
            arrive        <= 1'b0;
            travel_cnt    <= '0;
            dwell_cnt     <= '0;
        end else begin
            arrive  <= 1'b0;
            pending <= pend_base;
            case (state)
                IDLE: begin
                    if (req[current_floor]) begin
                        state                  <= DOOR_OPEN;
                        door                   <= 1'b1;
                        dwell_cnt              <= '0;
                        pending[current_floor] <= 1'b0;
                    end else if (above && (!below || dir_last_up)) begin
                        state       <= MOVING_UP;
                        motor_dir   <= DIR_UP;
                        dir_last_up <= 1'b1;
                        travel_cnt  <= '0;
                    end else if (below) begin
                        state       <= MOVING_DN;
                        motor_dir   <= DIR_DN;
                        dir_last_up <= 1'b0;
                        travel_cnt  <= '0;
                    end
                end
                MOVING_UP: begin
                    if (travel_cnt == TRV_LAST) begin
                        travel_cnt    <= '0;
                        current_floor <= floor_up;
                        arrive        <= 1'b1;
                        if (req[floor_up]) begin
                            state             <= DOOR_OPEN;
                            motor_dir         <= DIR_STOP;
                            door              <= 1'b1;
                            dwell_cnt         <= '0;
                            pending[floor_up] <= 1'b0;
                        end else if (!any_above(req, floor_up)) begin
                            state     <= IDLE;
                            motor_dir <= DIR_STOP;
                        end
                    end else begin
                        travel_cnt <= travel_cnt + TRV_W'(1);
                    end
                end
                MOVING_DN: begin
                    if (travel_cnt == TRV_LAST) begin
                        travel_cnt    <= '0;
                        current_floor <= floor_dn;
                        arrive        <= 1'b1;
                        if (req[floor_dn]) begin
                            state             <= DOOR_OPEN;
                            motor_dir         <= DIR_STOP;
                            door              <= 1'b1;
                            dwell_cnt         <= '0;
                            pending[floor_dn] <= 1'b0;
                        end else if (!any_below(req, floor_dn)) begin
                            state     <= IDLE;
                            motor_dir <= DIR_STOP;
                        end
                    end else begin
                        travel_cnt <= travel_cnt + TRV_W'(1);
                    end
                end
                DOOR_OPEN: begin
                    if (door_hold || call_req[current_floor]) begin
                        dwell_cnt <= '0;
                    end else if (dwell_cnt == DWL_LAST) begin
                        state     <= IDLE;
                        door      <= 1'b0;
                        dwell_cnt <= '0;
                    end else begin
                        dwell_cnt <= dwell_cnt + DWL_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    motor_dir <= DIR_STOP;
                    door      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed testbench for elevator_scan_ctrl (8 floors, 4-cycle travel, 6-cycle dwell).
module tb_elevator_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] call_req = 8'h00;
    logic       door_hold = 1'b0;
    logic [2:0] current_floor;
    logic [1:0] motor_dir;
    logic       door;
    logic [7:0] pending;
    logic       arrive;

    int tests = 0;
    int fails = 0;

    int rec_floor [0:3];
    int rec_cnt;
    logic saw_dn;

    elevator_scan_ctrl #(
        .NUM_FLOORS(8),
        .TRAVEL_CYC(4),
        .DOOR_CYC(6)
    ) dut (
        .clk(clk),
        .reset(reset),
        .call_req(call_req),
        .door_hold(door_hold),
        .current_floor(current_floor),
        .motor_dir(motor_dir),
        .door(door),
        .pending(pending),
        .arrive(arrive)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] v);
        call_req = v;
        tick();
        call_req = 8'h00;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((door || motor_dir != 2'b00) && n < 400) begin
            tick();
            n++;
        end
        tests++;
        if (n >= 400) begin
            fails++;
            $display("FAIL %s: timeout waiting for idle, got door=%0d dir=%0d expected 0/0",
                     name, door, motor_dir);
        end
    endtask

    task automatic wait_floor(input string name, input int f);
        int n;
        n = 0;
        while (int'(current_floor) != f && n < 400) begin
            tick();
            n++;
        end
        tests++;
        if (n >= 400) begin
            fails++;
            $display("FAIL %s: timeout, got floor %0d expected %0d", name, current_floor, f);
        end
    endtask

    // Record the floor at each door opening until n openings or timeout.
    task automatic record_opens(input string name, input int n);
        logic prev;
        int c;
        prev = door;
        rec_cnt = 0;
        saw_dn = 1'b0;
        c = 0;
        while (rec_cnt < n && c < 1000) begin
            tick();
            c++;
            if (door && !prev) begin
                rec_floor[rec_cnt] = int'(current_floor);
                rec_cnt++;
            end
            if (motor_dir == 2'b10) saw_dn = 1'b1;
            prev = door;
        end
        tests++;
        if (rec_cnt < n) begin
            fails++;
            $display("FAIL %s: got %0d door openings expected %0d", name, rec_cnt, n);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        check("reset_floor", int'(current_floor), 0);
        check("reset_dir", int'(motor_dir), 0);
        check("reset_door", int'(door), 0);
        check("reset_pending", int'(pending), 0);
        check("reset_arrive", int'(arrive), 0);
    endtask

    task automatic test_call_current();
        int cnt;
        int n;
        pulse(8'h01);
        check("t1_door_open", int'(door), 1);
        check("t1_pending0", int'(pending[0]), 0);
        cnt = 0;
        n = 0;
        while (door && n < 50) begin
            cnt++;
            tick();
            n++;
        end
        check("t1_dwell_len", cnt, 6);
        check("t1_dir_stop", int'(motor_dir), 0);
        check("t1_pending_after", int'(pending), 0);
    endtask

    task automatic test_travel();
        int moving;
        int arrives;
        int n;
        pulse(8'h20);
        check("t2_dir_up", int'(motor_dir), 1);
        check("t2_pending5", int'(pending[5]), 1);
        moving = 0;
        arrives = 0;
        n = 0;
        while (motor_dir == 2'b01 && n < 200) begin
            moving++;
            if (moving == 5) check("t2_floor1_after4", int'(current_floor), 1);
            tick();
            n++;
            if (arrive) arrives++;
        end
        check("t2_moving_cycles", moving, 20);
        check("t2_arrives", arrives, 5);
        check("t2_floor5", int'(current_floor), 5);
        check("t2_door", int'(door), 1);
        check("t2_pending_clr", int'(pending), 0);
        wait_idle("t2_close");
    endtask

    task automatic test_scan();
        apply_reset();
        pulse(8'h04);
        wait_floor("t3_reach2", 2);
        wait_idle("t3_idle2");
        pulse(8'h40);
        check("t3_dir_up", int'(motor_dir), 1);
        pulse(8'h02);
        wait_floor("t3_reach3", 3);
        pulse(8'h10);
        check("t3_pending", int'(pending), 8'h52);
        record_opens("t3_opens", 3);
        check("t3_open0", rec_floor[0], 4);
        check("t3_open1", rec_floor[1], 6);
        check("t3_open2", rec_floor[2], 1);
        check("t3_saw_down", int'(saw_dn), 1);
        wait_idle("t3_idle_end");
    endtask

    task automatic test_door_hold();
        int cnt;
        int i;
        // car is idle at floor 1
        pulse(8'h02);
        cnt = 0;
        i = 0;
        while (door && i < 100) begin
            cnt++;
            door_hold = (i < 10);
            tick();
            i++;
        end
        door_hold = 1'b0;
        check("t4_hold_len", cnt, 16);
        pulse(8'h02);
        cnt = 0;
        i = 0;
        while (door && i < 100) begin
            cnt++;
            call_req = (cnt == 4) ? 8'h02 : 8'h00;
            tick();
            call_req = 8'h00;
            if (cnt == 4) check("t4_call_not_latched", int'(pending), 0);
            i++;
        end
        check("t4_call_restart_len", cnt, 10);
    endtask

    task automatic test_dir_last_down();
        apply_reset();
        pulse(8'h20);
        wait_floor("t5_reach5", 5);
        wait_idle("t5_idle5");
        pulse(8'h10);
        check("t5_dir_dn_to4", int'(motor_dir), 2);
        wait_idle("t5_idle4");
        check("t5_at4", int'(current_floor), 4);
        pulse(8'h44);
        check("t5_first_dir", int'(motor_dir), 2);
        record_opens("t5_opens", 2);
        check("t5_open0", rec_floor[0], 2);
        check("t5_open1", rec_floor[1], 6);
        wait_idle("t5_idle_end");
    endtask

    task automatic test_reset_mid_travel();
        apply_reset();
        pulse(8'h80);
        wait_floor("t6_reach2", 2);
        tick();
        tick();
        check("t6_moving", int'(motor_dir), 1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_floor", int'(current_floor), 0);
        check("t6_dir", int'(motor_dir), 0);
        check("t6_pending", int'(pending), 0);
        check("t6_door", int'(door), 0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("t6_stay_idle", int'(motor_dir), 0);
        check("t6_stay_floor", int'(current_floor), 0);
    endtask

    initial begin
        test_reset();
        test_call_current();
        test_travel();
        test_scan();
        test_door_hold();
        test_dir_last_down();
        test_reset_mid_travel();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
